// File: rtl/uart_tx_serializer_if.sv
// +--------------------------------------------------------------------------+
// | uart_tx_serializer_if : encoder <-> UART transmit stage handshake bundle |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

interface uart_tx_serializer_if;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic [3:0] cur_state;
  logic       TxD;
  logic       Tx_BUSY;
  logic       Tx_DONE;

  modport master (
    output Tx_EN, Tx_WR, Tx_DATA,
    input  cur_state, TxD, Tx_BUSY, Tx_DONE
  );

  modport slave (
    input  Tx_EN, Tx_WR, Tx_DATA,
    output cur_state, TxD, Tx_BUSY, Tx_DONE
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// +--------------------------------------------------------------------------+
// | uart_tx_serializer : latches one byte, sends start/8N/[parity]/stop(s)    |
// | Option macro: UART_TX_PARITY_EN (even parity bit after D7)                |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx_serializer #(
  parameter int BAUD_DIV  = 16,
  parameter int STOP_BITS = 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  uart_tx_serializer_if.slave   tx
);

  localparam int               CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_START  = 4'd1;
  localparam logic [3:0] ST_D0     = 4'd2;
  localparam logic [3:0] ST_D7     = 4'd9;
`ifdef UART_TX_PARITY_EN
  localparam logic [3:0] ST_PARITY = 4'd10;
`endif
  localparam logic [3:0] ST_STOP1  = 4'd11;
  localparam logic [3:0] ST_STOP2  = 4'd12;

  logic [3:0]       r_state;
  logic [3:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_shift;
  logic             w_bit_end;
  logic             w_accept;
  logic [2:0]       w_bit_idx;
  logic             w_txd;
  logic             w_busy;
  logic             w_done;

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign w_accept  = (r_state == ST_IDLE) && tx.Tx_WR && tx.Tx_EN;
  assign w_bit_idx = 3'(r_state - ST_D0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Baud counter restarts on every state change so each state lasts BAUD_DIV clks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      if ((r_state == ST_IDLE) || (w_state_nxt != r_state)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_shift <= tx.Tx_DATA;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_START;
        end
      end
      ST_D7: begin
        if (w_bit_end) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP1;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP1;
        end
      end
`endif
      ST_STOP1: begin
        if (w_bit_end) begin
          w_state_nxt = (STOP_BITS == 2) ? ST_STOP2 : ST_IDLE;
        end
      end
      ST_STOP2: begin
        if ((STOP_BITS != 2) || w_bit_end) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        // START and D0..D6 simply step to the next encoding; anything else recovers to IDLE.
        if ((r_state >= ST_START) && (r_state < ST_D7)) begin
          if (w_bit_end) begin
            w_state_nxt = r_state + 4'd1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_txd  = 1'b1;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_txd = 1'b1;
      end
      ST_START: begin
        w_txd  = 1'b0;
        w_busy = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        w_txd  = ^r_shift;
        w_busy = 1'b1;
      end
`endif
      ST_STOP1: begin
        w_busy = 1'b1;
        w_done = w_bit_end && (STOP_BITS != 2);
      end
      ST_STOP2: begin
        if (STOP_BITS == 2) begin
          w_busy = 1'b1;
          w_done = w_bit_end;
        end
      end
      default: begin
        if ((r_state >= ST_D0) && (r_state <= ST_D7)) begin
          w_txd  = r_shift[w_bit_idx];
          w_busy = 1'b1;
        end
      end
    endcase
  end

  assign tx.cur_state = r_state;
  assign tx.TxD       = w_txd;
  assign tx.Tx_BUSY   = w_busy;
  assign tx.Tx_DONE   = w_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// +--------------------------------------------------------------------------+
// | tb_uart_tx_serializer : directed frames on a 1-stop and a 2-stop instance |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_serializer;

  localparam int BAUD_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  uart_tx_serializer_if bus1 ();
  uart_tx_serializer_if bus2 ();

  uart_tx_serializer #(.BAUD_DIV(BAUD_DIV), .STOP_BITS(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .tx    (bus1.slave)
  );

  uart_tx_serializer #(.BAUD_DIV(BAUD_DIV), .STOP_BITS(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .tx    (bus2.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] f_state(input logic d);
    return d ? bus2.cur_state : bus1.cur_state;
  endfunction
  function automatic logic f_txd(input logic d);
    return d ? bus2.TxD : bus1.TxD;
  endfunction
  function automatic logic f_busy(input logic d);
    return d ? bus2.Tx_BUSY : bus1.Tx_BUSY;
  endfunction
  function automatic logic f_done(input logic d);
    return d ? bus2.Tx_DONE : bus1.Tx_DONE;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic d, input logic wr, input logic [7:0] data);
    if (d) begin
      bus2.Tx_WR   = wr;
      bus2.Tx_DATA = data;
    end else begin
      bus1.Tx_WR   = wr;
      bus1.Tx_DATA = data;
    end
  endtask

  task automatic chk_idle(input string tag, input logic d);
    chk({tag, ".state"}, 32'(f_state(d)), 32'd0);
    chk({tag, ".txd"},   32'(f_txd(d)),   32'd1);
    chk({tag, ".busy"},  32'(f_busy(d)),  32'd0);
    chk({tag, ".done"},  32'(f_done(d)),  32'd0);
  endtask

  // Entered on frame clk 1 (the start-bit cycle); leaves on the first IDLE cycle after the frame.
  task automatic run_frame(input string tag, input logic d, input logic [7:0] data,
                           input int stops, input int poke_k, input int hold_k,
                           input logic [7:0] nd, output logic [11:0] seq, output int done_k);
    int         len;
    int         b;
    logic       eb;
    logic [3:0] es;
    len    = (1 + 8 + PAR + stops) * BAUD_DIV;
    seq    = '0;
    done_k = 0;
    for (int k = 1; k <= len; k++) begin
      b = (k - 1) / BAUD_DIV;
      if (b == 0) begin
        eb = 1'b0; es = 4'd1;
      end else if (b <= 8) begin
        eb = data[b-1]; es = 4'(b + 1);
      end else if ((PAR == 1) && (b == 9)) begin
        eb = ^data; es = 4'd10;
      end else begin
        eb = 1'b1; es = 4'(11 + b - 9 - PAR);
      end
      chk($sformatf("%s.k%0d.txd", tag, k),   32'(f_txd(d)),   32'(eb));
      chk($sformatf("%s.k%0d.state", tag, k), 32'(f_state(d)), 32'(es));
      chk($sformatf("%s.k%0d.busy", tag, k),  32'(f_busy(d)),  32'd1);
      chk($sformatf("%s.k%0d.done", tag, k),  32'(f_done(d)),  32'(k == len));
      if (((k - 1) % BAUD_DIV) == 1) seq[b] = f_txd(d);
      if (f_done(d) === 1'b1) done_k = k;
      drive_wr(d, (k == poke_k) || ((hold_k != 0) && (k >= hold_k)),
               (k == poke_k) ? 8'hFF : nd);
      tick();
    end
    chk_idle({tag, ".end"}, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] seq;
    int          done_k;
    logic        saw_done;

    bus1.Tx_EN = 1'b1; bus1.Tx_WR = 1'b1; bus1.Tx_DATA = 8'h55;
    bus2.Tx_EN = 1'b1; bus2.Tx_WR = 1'b1; bus2.Tx_DATA = 8'h55;
    reset = 1'b0;

    // Reset dominates a held write strobe.
    tick(); chk_idle("rst1.a", 1'b0); chk_idle("rst2.a", 1'b1);
    tick(); chk_idle("rst1.b", 1'b0); chk_idle("rst2.b", 1'b1);
    drive_wr(1'b0, 1'b0, 8'h00);
    drive_wr(1'b1, 1'b0, 8'h00);
    bus2.Tx_EN = 1'b0;
    reset = 1'b1;
    tick(); chk_idle("rel", 1'b0);

    // 8'h0D, plain frame.
    drive_wr(1'b0, 1'b1, 8'h0D);
    tick();
    run_frame("f0D", 1'b0, 8'h0D, 1, 0, 0, 8'h00, seq, done_k);
    chk("f0D.bits", 32'(seq[8:0]), 32'(9'b000011010));
    chk("f0D.after_d7", 32'(seq[9]), 32'd1);
`ifdef UART_TX_PARITY_EN
    chk("f0D.done_k", done_k, 32'd44);

    drive_wr(1'b0, 1'b1, 8'h0F);
    tick();
    run_frame("f0F", 1'b0, 8'h0F, 1, 0, 0, 8'h00, seq, done_k);
    chk("f0F.parity", 32'(seq[9]), 32'd0);
    chk("f0F.done_k", done_k, 32'd44);

    drive_wr(1'b0, 1'b1, 8'h07);
    tick();
    run_frame("f07", 1'b0, 8'h07, 1, 0, 0, 8'h00, seq, done_k);
    chk("f07.parity", 32'(seq[9]), 32'd1);
`else
    chk("f0D.done_k", done_k, 32'd40);
`endif

    // Write during D3 is dropped; held write restarts after exactly one idle clk.
    drive_wr(1'b0, 1'b1, 8'h3C);
    tick();
    run_frame("f3C", 1'b0, 8'h3C, 1, 18, 30, 8'hA5, seq, done_k);
    chk("f3C.bits", 32'(seq[8:0]), 32'(9'b001111000));
    tick();
    run_frame("fA5", 1'b0, 8'hA5, 1, 0, 0, 8'h00, seq, done_k);
    chk("fA5.bits", 32'(seq[8:0]), 32'(9'b101001010));

    // Reset during D4 aborts the frame.
    drive_wr(1'b0, 1'b1, 8'h5A);
    tick();
    drive_wr(1'b0, 1'b0, 8'h00);
    repeat (21) tick();
    chk("f5A.k22.state", 32'(f_state(1'b0)), 32'd6);
    chk("f5A.k22.txd",   32'(f_txd(1'b0)),   32'd1);
    reset = 1'b0;
    tick(); chk_idle("abort", 1'b0);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (f_done(1'b0) !== 1'b0 || f_busy(1'b0) !== 1'b0) saw_done = 1'b1;
    end
    chk("abort.quiet", 32'(saw_done), 32'd0);
    drive_wr(1'b0, 1'b1, 8'h96);
    tick();
    run_frame("f96", 1'b0, 8'h96, 1, 0, 0, 8'h00, seq, done_k);
    chk("f96.bits", 32'(seq[8:0]), 32'(9'b100101100));

    // Two stop bits, enable dropped during START.
    bus2.Tx_EN = 1'b1;
    drive_wr(1'b1, 1'b1, 8'hC3);
    tick();
    bus2.Tx_EN = 1'b0;
    run_frame("fC3", 1'b1, 8'hC3, 2, 0, 0, 8'h00, seq, done_k);
    chk("fC3.bits", 32'(seq[8:0]), 32'(9'b110000110));
    chk("fC3.stop2", 32'(seq[10]), 32'd1);
`ifdef UART_TX_PARITY_EN
    chk("fC3.done_k", done_k, 32'd48);
`else
    chk("fC3.done_k", done_k, 32'd44);
`endif
    drive_wr(1'b1, 1'b1, 8'h81);
    repeat (6) tick();
    chk_idle("en_off", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
